// File: rtl/eth_rx_fcs_check.sv
// Ethernet receive FCS checker: strips the 4-byte FCS through a delay line,
// checks the CRC-32 residue and reports per-frame status with Frame_done.
module eth_rx_fcs_check #(
    parameter int unsigned MIN_FRAME = 64
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Rx_valid,
    input  logic [7:0]  Rx_data,
    input  logic        Rx_sof,
    input  logic        Rx_eof,
    output logic        Out_valid,
    output logic [7:0]  Out_data,
    output logic        Out_sof,
    output logic        Out_eof,
    output logic        Frame_done,
    output logic        Crc_ok,
    output logic        Crc_err,
    output logic        Runt,
    output logic        Abort,
    output logic [15:0] Frame_len
);

    localparam logic [31:0] CRC_POLY    = 32'h04C11DB7;
    localparam logic [31:0] CRC_RESIDUE = 32'hC704DD7B;

    typedef enum logic [1:0] {IDLE, FILL, PASS} state_t;

    state_t      state_q;
    logic [31:0] crc_q;
    logic [31:0] line_q;
    logic [2:0]  cnt_q;
    logic [15:0] lenCnt_q;
    logic        firstOut_q;

    logic        outValid_q;
    logic [7:0]  outData_q;
    logic        outSof_q;
    logic        outEof_q;
    logic        frameDone_q;
    logic        crcOk_q;
    logic        crcErr_q;
    logic        runt_q;
    logic        abort_q;
    logic [15:0] frameLen_q;

    logic [31:0] crc_d;
    logic [15:0] lenNext_d;
    logic        good_d;

    // Serial CRC register fed one byte, bit 0 first as it appears on the wire.
    function automatic logic [31:0] crcByte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[31] ^ d[i])
                r = {r[30:0], 1'b0} ^ CRC_POLY;
            else
                r = {r[30:0], 1'b0};
        end
        return r;
    endfunction

    always_comb begin
        crc_d     = crcByte(Rx_sof ? 32'hFFFFFFFF : crc_q, Rx_data);
        lenNext_d = (lenCnt_q == 16'hFFFF) ? lenCnt_q : lenCnt_q + 16'd1;
        good_d    = (crc_d == CRC_RESIDUE) && (lenNext_d >= 16'd5);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= IDLE;
            crc_q       <= 32'hFFFFFFFF;
            line_q      <= 32'h0;
            cnt_q       <= 3'd0;
            lenCnt_q    <= 16'd0;
            firstOut_q  <= 1'b0;
            outValid_q  <= 1'b0;
            outData_q   <= 8'h00;
            outSof_q    <= 1'b0;
            outEof_q    <= 1'b0;
            frameDone_q <= 1'b0;
            crcOk_q     <= 1'b0;
            crcErr_q    <= 1'b0;
            runt_q      <= 1'b0;
            abort_q     <= 1'b0;
            frameLen_q  <= 16'd0;
        end else begin
            outValid_q  <= 1'b0;
            outData_q   <= 8'h00;
            outSof_q    <= 1'b0;
            outEof_q    <= 1'b0;
            frameDone_q <= 1'b0;
            crcOk_q     <= 1'b0;
            crcErr_q    <= 1'b0;
            runt_q      <= 1'b0;
            abort_q     <= 1'b0;
            frameLen_q  <= 16'd0;
            if (Rx_valid) begin
                if (Rx_sof) begin
                    // A new SOF inside a frame closes the old one as aborted.
                    if (state_q != IDLE) begin
                        frameDone_q <= 1'b1;
                        abort_q     <= 1'b1;
                        crcErr_q    <= 1'b1;
                        runt_q      <= (32'(lenCnt_q) < MIN_FRAME);
                        frameLen_q  <= lenCnt_q;
                    end
                    crc_q      <= crc_d;
                    lenCnt_q   <= 16'd1;
                    line_q     <= {24'h0, Rx_data};
                    cnt_q      <= 3'd1;
                    firstOut_q <= 1'b1;
                    if (Rx_eof) begin
                        if (state_q == IDLE) begin
                            frameDone_q <= 1'b1;
                            crcErr_q    <= 1'b1;
                            runt_q      <= (32'd1 < MIN_FRAME);
                            frameLen_q  <= 16'd1;
                        end
                        state_q <= IDLE;
                    end else begin
                        state_q <= FILL;
                    end
                end else if (state_q != IDLE) begin
                    crc_q    <= crc_d;
                    lenCnt_q <= lenNext_d;
                    line_q   <= {line_q[23:0], Rx_data};
                    if (state_q == PASS) begin
                        outValid_q <= 1'b1;
                        outData_q  <= line_q[31:24];
                        outSof_q   <= firstOut_q;
                        outEof_q   <= Rx_eof;
                        firstOut_q <= 1'b0;
                    end
                    if (Rx_eof) begin
                        frameDone_q <= 1'b1;
                        crcOk_q     <= good_d;
                        crcErr_q    <= !good_d;
                        runt_q      <= (32'(lenNext_d) < MIN_FRAME);
                        frameLen_q  <= lenNext_d;
                        state_q     <= IDLE;
                    end else if (state_q == FILL) begin
                        cnt_q <= cnt_q + 3'd1;
                        if (cnt_q == 3'd3)
                            state_q <= PASS;
                    end
                end
            end
        end
    end

    assign Out_valid  = outValid_q;
    assign Out_data   = outData_q;
    assign Out_sof    = outSof_q;
    assign Out_eof    = outEof_q;
    assign Frame_done = frameDone_q;
    assign Crc_ok     = crcOk_q;
    assign Crc_err    = crcErr_q;
    assign Runt       = runt_q;
    assign Abort      = abort_q;
    assign Frame_len  = frameLen_q;

endmodule
